// File: rtl/mmio_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mmio_pkg
// Description : Shared select encoding, default I/O address map and the
//               address decode helper for the CPU data-memory bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package mmio_pkg;

  // Target of a CPU data access; SEL_RAM is the pass-through default.
  typedef enum logic [1:0] {
    SEL_RAM   = 2'd0,
    SEL_INPUT = 2'd1,
    SEL_SEG1  = 2'd2,
    SEL_SEG2  = 2'd3
  } io_sel_t;

  // Reserved low addresses; everything else belongs to RAM.
  localparam logic [15:0] C_INPUT_BEGIN = 16'h0000;
  localparam logic [15:0] C_SEG1_BEGIN  = 16'h0001;
  localparam logic [15:0] C_SEG2_BEGIN  = 16'h0002;

  // Exact 16-bit match against each I/O address; no aliasing or wrap.
  function automatic io_sel_t decode_addr(input logic [15:0] addr,
                                          input logic [15:0] a_input,
                                          input logic [15:0] a_seg1,
                                          input logic [15:0] a_seg2);
    io_sel_t sel;
    sel = SEL_RAM;
    if (addr == a_input)     sel = SEL_INPUT;
    else if (addr == a_seg1) sel = SEL_SEG1;
    else if (addr == a_seg2) sel = SEL_SEG2;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_bridge_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Two-flop synchronizer plus whole-word stability counter for
//               the 16 switch inputs. A new word is accepted only after it
//               has been seen unchanged for DEBOUNCE_CYCLES further edges.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] raw,
  output logic [15:0] stable
);

  localparam logic [15:0] C_CNT_LAST = DEBOUNCE_CYCLES - 16'd1;

  logic [15:0] sync1_q, sync1_d;
  logic [15:0] sync2_q, sync2_d;
  logic [15:0] cand_q,  cand_d;
  logic [15:0] cnt_q,   cnt_d;
  logic [15:0] stable_q, stable_d;

  // Next state: restart the count on any change, promote after a full run.
  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == C_CNT_LAST) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/mmio_bridge.sv
`default_nettype none
// ============================================================================
// Module      : mmio_bridge
// Description : Decodes the CPU data address into switch input, two display
//               registers or RAM pass-through. I/O reads travel through a
//               tag pipeline as deep as the RAM latency so the CPU sees every
//               read after the same number of edges regardless of target.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_bridge
  import mmio_pkg::*;
#(
  parameter logic [15:0] INPUT_BEGIN     = C_INPUT_BEGIN,
  parameter logic [15:0] SEG1_BEGIN      = C_SEG1_BEGIN,
  parameter logic [15:0] SEG2_BEGIN      = C_SEG2_BEGIN,
  parameter int unsigned READ_LATENCY    = 2,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_wren,
  input  logic [15:0] cpu_data,
  output logic [15:0] cpu_q,
  output logic [15:0] ram_address,
  output logic        ram_wren,
  output logic [15:0] ram_data,
  input  logic [15:0] ram_q,
  input  logic [15:0] sw_in,
  output logic [15:0] SEG1,
  output logic [15:0] SEG2
);

  localparam int unsigned C_TAIL = READ_LATENCY - 1;

  io_sel_t     w_sel;
  logic [15:0] w_stable;
  logic [15:0] seg1_q, seg1_d;
  logic [15:0] seg2_q, seg2_d;
  logic [15:0] io_val_d;
  io_sel_t     sel_pipe_q [READ_LATENCY];
  logic [15:0] val_pipe_q [READ_LATENCY];

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock   (clock),
    .reset_n (reset_n),
    .raw     (sw_in),
    .stable  (w_stable)
  );

  assign w_sel       = decode_addr(cpu_address, INPUT_BEGIN, SEG1_BEGIN, SEG2_BEGIN);
  assign ram_address = cpu_address;
  assign ram_data    = cpu_data;
  // I/O addresses must never disturb the RAM contents behind them.
  assign ram_wren    = (w_sel == SEL_RAM) ? cpu_wren : 1'b0;

  // Display register loads, and the value an I/O read captures this edge
  // (display reads see the value being written in the same cycle).
  always_comb begin
    seg1_d   = seg1_q;
    seg2_d   = seg2_q;
    io_val_d = '0;
    if (cpu_wren && (w_sel == SEL_SEG1)) seg1_d = cpu_data;
    if (cpu_wren && (w_sel == SEL_SEG2)) seg2_d = cpu_data;
    case (w_sel)
      SEL_INPUT: io_val_d = w_stable;
      SEL_SEG1:  io_val_d = seg1_d;
      SEL_SEG2:  io_val_d = seg2_d;
      default:   io_val_d = '0;
    endcase
  end

  // Display registers; reset wins over a simultaneous write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      seg1_q <= '0;
      seg2_q <= '0;
    end else begin
      seg1_q <= seg1_d;
      seg2_q <= seg2_d;
    end
  end

  // Read-tag pipeline; reset drops in-flight I/O reads back to RAM pass-through.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        sel_pipe_q[i] <= SEL_RAM;
        val_pipe_q[i] <= '0;
      end
    end else begin
      sel_pipe_q[0] <= w_sel;
      val_pipe_q[0] <= io_val_d;
      for (int i = 1; i < READ_LATENCY; i++) begin
        sel_pipe_q[i] <= sel_pipe_q[i-1];
        val_pipe_q[i] <= val_pipe_q[i-1];
      end
    end
  end

  assign cpu_q = (sel_pipe_q[C_TAIL] == SEL_RAM) ? ram_q : val_pipe_q[C_TAIL];
  assign SEG1  = seg1_q;
  assign SEG2  = seg2_q;

endmodule
`default_nettype wire
